fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage feeding the decode stage of the MIPS core.
- Owns the program counter and issues one instruction-memory request at a time.
- Delivers fetched instruction/PC pairs downstream over a valid/ready interface.
- Redirects and flushes on branch/jump targets resolved later in the pipeline.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request to instruction memory
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  request address (current PC)
imem_resp_valid  input  1  instruction word returned this cycle
imem_resp_data  input  32  returned instruction word
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_target  input  32  new PC on redirect
if_valid  output  1  if_instr/if_pc hold a valid fetched instruction
if_ready  input  1  decode accepts this cycle
if_instr  output  32  fetched instruction
if_pc  output  32  address of if_instr
if_pc_plus4  output  32  if_pc + 4, for link/branch arithmetic

Behaviour:
- Reset (sync): pc=RESET_PC, state=S_REQ, drop=0, buf_valid=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=4. imem_req_valid forced 0 while reset is high.
- imem_req_addr = pc at all times.
- imem_req_valid = (state==S_REQ) && !redirect_valid && !reset.
- State S_REQ: on request handshake, go to S_WAIT. pc is not advanced yet.
- State S_WAIT: on imem_resp_valid with drop=1, discard the word, clear drop, go to S_REQ.
- State S_WAIT, non-dropped response: pc<=pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0).
  - If the output slot is free (if_valid==0, or if_ready==1 this cycle), load if_instr/if_pc/if_pc_plus4 and set if_valid. Go to S_REQ.
  - Otherwise store the word and its PC in buf, set buf_valid, go to S_HOLD.
- State S_HOLD: no requests issued. When if_ready==1, move buf to the output regs (if_valid stays 1), clear buf_valid, go to S_REQ.
- Output regs: if_valid clears on (if_valid && if_ready) unless reloaded in the same cycle. Outputs stay stable while if_valid && !if_ready.
- Redirect has highest priority. On redirect_valid:
  - pc<=redirect_target with bits [1:0] forced to 00.
  - if_valid<=0 and buf_valid<=0.
  - In S_REQ: stay in S_REQ. No request is issued that cycle.
  - In S_WAIT without resp this cycle: set drop=1, stay in S_WAIT.
  - In S_WAIT with resp this cycle: discard the resp, drop=0, go to S_REQ.
  - In S_HOLD: go to S_REQ.
- Latency: request accepted at cycle N, response at N+k (k≥1), if_valid high at N+k+1. Peak throughput with 1-cycle memory is one instruction per 2 cycles.
- Only one request is outstanding at a time. imem_resp_valid outside S_WAIT is ignored.
- Reset asserted mid-operation overrides everything. An in-flight response arriving after reset is ignored, because the state is S_REQ.

Decomposition:
- Shared package mips_pkg: ADDR_W=32, INSTR_W=32, PC_INCR=4, and the fetch state encoding (S_REQ, S_WAIT, S_HOLD).
- One sub-module, pc_reg: 32-bit register with synchronous reset to RESET_PC, load enable, and load value. It is driven by the fetch FSM.

Test Plan:
- Reset, then 1-cycle memory returning addr^32'hA5A50000, if_ready=1 -> imem_req_addr sequence 0,4,8. if_pc sequence 0,4,8, each with matching if_instr and if_pc_plus4=if_pc+4.
- Backpressure: if_ready=0 after the first instruction (pc 0).
  - Required: response for 4 is buffered, state S_HOLD, no request for 8 while held.
  - Release if_ready -> if_pc 0 consumed, then 4, then a request for 8.
- Redirect to 0x100 while the response for 0x8 is outstanding, memory latency 3 -> 0x8 word never appears on if_*. Next imem_req_addr=0x100, next if_pc=0x100.
- Redirect to 0x203 in the same cycle as imem_resp_valid for 0xC -> response discarded. Next request is 0x200; imem_req_valid is low in the redirect cycle even though imem_req_ready=1.
- RESET_PC=32'hFFFFFFF8 -> if_pc sequence FFFFFFF8, FFFFFFFC, 00000000. Asserting reset mid-stream -> if_valid=0 next cycle, next request addr FFFFFFF8, and a late response is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and fetch state encoding for the MIPS core
package mips_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with synchronous reset and load enable
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: one outstanding imem request, skid buffer, redirect flush
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h00000000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4
);

    fetch_state_t       state;
    logic               drop;
    logic               buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  pc_next;
    logic               pc_load;
    logic               resp_take;
    logic               slot_free;

    assign pc_plus4  = pc + PC_INCR;
    assign resp_take = (state == S_WAIT) && imem_resp_valid && !drop;
    assign slot_free = !if_valid || if_ready;
    // pc advances only once the word for it is actually in hand
    assign pc_load   = redirect_valid || resp_take;
    assign pc_next   = redirect_valid ? {redirect_target[ADDR_W-1:2], 2'b00} : pc_plus4;

    assign imem_req_addr  = pc;
    assign imem_req_valid = (state == S_REQ) && !redirect_valid && !reset;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .load_value(pc_next),
        .pc        (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            drop        <= 1'b0;
            buf_valid   <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus4 <= PC_INCR;
        end else if (redirect_valid) begin
            if_valid  <= 1'b0;
            buf_valid <= 1'b0;
            case (state)
                S_WAIT: begin
                    // a response still in flight belongs to the old path
                    if (imem_resp_valid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else if (slot_free) begin
                            if_instr    <= imem_resp_data;
                            if_pc       <= pc;
                            if_pc_plus4 <= pc_plus4;
                            if_valid    <= 1'b1;
                            state       <= S_REQ;
                        end else begin
                            buf_instr <= imem_resp_data;
                            buf_pc    <= pc;
                            buf_valid <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (if_ready && buf_valid) begin
                        if_instr    <= buf_instr;
                        if_pc       <= buf_pc;
                        if_pc_plus4 <= buf_pc + PC_INCR;
                        if_valid    <= 1'b1;
                        buf_valid   <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
